// File: rtl/pwm_gen.sv
// Duty-cycle PWM generator stepped by the rising edges of a divided clock.
// Duty updates are double-buffered so they only take effect at period boundaries.
module pwm_gen #(
    parameter int PERIOD = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             en,
    input  logic [CNT_W-1:0] duty_data,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_end
);

    localparam logic [CNT_W-1:0] LP_PERIOD = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(PERIOD - 1);

    logic             r_tick_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_duty_act;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_ready;
    logic             r_pwm;
    logic             r_period_end;

    logic             w_step;
    logic             w_wrap;
    logic             w_xfer;
    logic [CNT_W-1:0] w_clamped;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_pend_nxt;
    logic             w_pwm_nxt;
    logic             w_period_end_nxt;

    assign w_step    = tick_in & ~r_tick_q;
    assign w_wrap    = en & w_step & (r_cnt == LP_LAST);
    assign w_xfer    = duty_valid & r_ready;
    assign w_clamped = (duty_data > LP_PERIOD) ? LP_PERIOD : duty_data;

    // A transfer is only possible with nothing pending, so it never collides
    // with a pending value being promoted; the new value always lands in shadow.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_duty_nxt       = r_duty_act;
        w_shadow_nxt     = r_shadow;
        w_pend_nxt       = r_pend;
        w_pwm_nxt        = 1'b0;
        w_period_end_nxt = 1'b0;

        if (en) begin
            if (w_step) begin
                w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
            end
            if (w_wrap && r_pend) begin
                w_duty_nxt = r_shadow;
                w_pend_nxt = 1'b0;
            end
        end else begin
            w_cnt_nxt = '0;
            if (r_pend) begin
                w_duty_nxt = r_shadow;
                w_pend_nxt = 1'b0;
            end
        end

        if (w_xfer) begin
            w_shadow_nxt = w_clamped;
            w_pend_nxt   = 1'b1;
        end

        w_pwm_nxt        = en & (w_cnt_nxt < w_duty_nxt);
        w_period_end_nxt = w_wrap;
    end

    // tick_q resets high so a tick already high at release is not a step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_q     <= 1'b1;
            r_cnt        <= '0;
            r_duty_act   <= '0;
            r_shadow     <= '0;
            r_pend       <= 1'b0;
            r_ready      <= 1'b0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_tick_q     <= tick_in;
            r_cnt        <= w_cnt_nxt;
            r_duty_act   <= w_duty_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pend       <= w_pend_nxt;
            r_ready      <= ~w_pend_nxt;
            r_pwm        <= w_pwm_nxt;
            r_period_end <= w_period_end_nxt;
        end
    end

    assign duty_ready = r_ready;
    assign pwm_out    = r_pwm;
    assign period_end = r_period_end;

endmodule
